// File: rtl/datapath_mc.sv
// Multi-cycle MIPS-style datapath: IDLE -> DECODE -> EXEC -> (MEM) -> WB,
// with a start/done handshake, a data-memory req/ack port and a register
// file whose register 0 is hardwired to zero.
module datapath_mc #(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [31:0]     instruction,
    input  logic            ALUScr,
    input  logic            RegWrite,
    input  logic            RegDst,
    input  logic            MemRead,
    input  logic            MemWrite,
    input  logic            MemtoReg,
    input  logic [3:0]      ALUControl,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_ack,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [XLEN-1:0] ALUResult,
    output logic [XLEN-1:0] imm_ext,
    output logic            Zero,
    output logic            busy,
    output logic            done
);

    localparam int         IW     = $clog2(NREG);
    localparam logic [5:0] NREG_W = 6'(NREG);

    typedef enum logic [2:0] {IDLE, DECODE, EXEC, MEM, WB} state_t;

    state_t state, state_next;

    // Instruction fields and controls captured at start
    logic [25:0]     ir;
    logic            alu_src_q, reg_write_q, reg_dst_q;
    logic            mem_read_q, mem_write_q, mem_to_reg_q;
    logic [3:0]      alu_ctl_q;

    logic [XLEN-1:0] rf [NREG];
    logic [XLEN-1:0] a_q, b_q, alu_out_q, mdr_q, imm_q;

    logic [4:0]      rs, rt, rd, wr_idx;
    logic [XLEN-1:0] rs_data, rt_data, opb, alu_res, wb_data;
    logic            slt;
    logic            unused_opcode;

    assign rs     = ir[25:21];
    assign rt     = ir[20:16];
    assign rd     = ir[15:11];
    assign wr_idx = reg_dst_q ? rd : rt;
    assign wb_data = mem_to_reg_q ? mdr_q : alu_out_q;
    assign unused_opcode = ^instruction[31:26];

    assign mem_req   = (state == MEM);
    assign mem_we    = (state == MEM) && mem_write_q;
    assign mem_addr  = alu_out_q;
    assign mem_wdata = b_q;
    assign ALUResult = alu_out_q;
    assign imm_ext   = imm_q;
    assign Zero      = (alu_out_q == '0);
    assign busy      = (state != IDLE);
    assign done      = (state == WB);

    // Register-file read ports; r0 and out-of-range indices read as zero
    always_comb begin
        rs_data = '0;
        rt_data = '0;
        if (rs != 5'd0 && {1'b0, rs} < NREG_W) rs_data = rf[rs[IW-1:0]];
        if (rt != 5'd0 && {1'b0, rt} < NREG_W) rt_data = rf[rt[IW-1:0]];
    end

    // ALU on the A/B(or immediate) operand pair
    always_comb begin
        opb     = alu_src_q ? imm_q : b_q;
        slt     = $signed(a_q) < $signed(opb);
        alu_res = '0;
        case (alu_ctl_q)
            4'b0000: alu_res = a_q & opb;
            4'b0001: alu_res = a_q | opb;
            4'b0010: alu_res = a_q + opb;
            4'b0011: alu_res = a_q ^ opb;
            4'b0110: alu_res = a_q - opb;
            4'b1100: alu_res = ~(a_q | opb);
            4'b0111: alu_res = {{(XLEN-1){1'b0}}, slt};
            4'b1000: alu_res = a_q << opb[4:0];
            default: alu_res = '0;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // FSM next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = DECODE;
            DECODE:  state_next = EXEC;
            EXEC:    state_next = (mem_read_q || mem_write_q) ? MEM : WB;
            MEM:     if (mem_ack) state_next = WB;
            WB:      state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath registers, each loaded in its own phase
    always_ff @(posedge clk) begin
        if (rst) begin
            ir           <= '0;
            alu_src_q    <= 1'b0;
            reg_write_q  <= 1'b0;
            reg_dst_q    <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            alu_ctl_q    <= '0;
            a_q          <= '0;
            b_q          <= '0;
            imm_q        <= '0;
            alu_out_q    <= '0;
            mdr_q        <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    ir           <= instruction[25:0];
                    alu_src_q    <= ALUScr;
                    reg_write_q  <= RegWrite;
                    reg_dst_q    <= RegDst;
                    mem_read_q   <= MemRead;
                    mem_write_q  <= MemWrite;
                    mem_to_reg_q <= MemtoReg;
                    alu_ctl_q    <= ALUControl;
                end
                DECODE: begin
                    a_q   <= rs_data;
                    b_q   <= rt_data;
                    imm_q <= {{(XLEN-16){ir[15]}}, ir[15:0]};
                end
                EXEC: alu_out_q <= alu_res;
                // A combined read+write request is a write, so MDR keeps its value
                MEM: if (mem_ack && mem_read_q && !mem_write_q) mdr_q <= mem_rdata;
                default: ;
            endcase
        end
    end

    // Register-file write in WB; r0 and out-of-range indices are dropped
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREG; i++) rf[i] <= '0;
        end else if (state == WB && reg_write_q && wr_idx != 5'd0 && {1'b0, wr_idx} < NREG_W) begin
            rf[wr_idx[IW-1:0]] <= wb_data;
        end
    end

endmodule

// File: tb/tb_datapath_mc.sv
// Directed self-checking bench for datapath_mc.
module tb_datapath_mc;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] instruction;
    logic        ALUScr, RegWrite, RegDst, MemRead, MemWrite, MemtoReg;
    logic [3:0]  ALUControl;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata, ALUResult, imm_ext;
    logic        Zero, busy, done;

    always #5 clk = ~clk;

    datapath_mc #(.XLEN(32), .NREG(32)) dut (
        .clk(clk), .rst(rst), .start(start), .instruction(instruction),
        .ALUScr(ALUScr), .RegWrite(RegWrite), .RegDst(RegDst),
        .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
        .ALUControl(ALUControl), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .ALUResult(ALUResult), .imm_ext(imm_ext),
        .Zero(Zero), .busy(busy), .done(done)
    );

    int tests = 0;
    int fails = 0;

    // Observations captured while an instruction runs
    int          obs_req_cycles;
    logic        obs_stable, obs_we, obs_zero;
    logic [31:0] obs_addr, obs_wdata, obs_result, obs_imm;

    function automatic logic [31:0] itype(input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
        return {6'd0, rs, rt, imm};
    endfunction

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        return {6'd0, rs, rt, rd, 11'd0};
    endfunction

    task automatic issue(input logic [31:0] ins, input logic src, input logic rw, input logic dst,
                         input logic mr, input logic mw, input logic m2r, input logic [3:0] ctl);
        @(posedge clk); #1;
        instruction = ins; ALUScr = src; RegWrite = rw; RegDst = dst;
        MemRead = mr; MemWrite = mw; MemtoReg = m2r; ALUControl = ctl;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Cycle numbering: cycle 1 follows the edge that sampled start.
    // Acts as the memory: acks on MEM cycle index ack_delay (0 = first).
    task automatic wait_done(input int ack_delay, output int cyc);
        cyc = -1;
        obs_req_cycles = 0;
        obs_stable = 1'b1;
        mem_ack = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (mem_req === 1'b1) begin
                if (obs_req_cycles == 0) begin
                    obs_we = mem_we; obs_addr = mem_addr; obs_wdata = mem_wdata;
                end else if (mem_we !== obs_we || mem_addr !== obs_addr || mem_wdata !== obs_wdata) begin
                    obs_stable = 1'b0;
                end
                mem_ack = (obs_req_cycles == ack_delay);
                obs_req_cycles++;
            end else begin
                mem_ack = 1'b0;
            end
            if (done === 1'b1) begin
                cyc = c;
                obs_result = ALUResult;
                obs_zero = Zero;
                obs_imm = imm_ext;
                break;
            end
        end
        mem_ack = 1'b0;
    endtask

    task automatic run(input logic [31:0] ins, input logic src, input logic rw, input logic dst,
                       input logic mr, input logic mw, input logic m2r, input logic [3:0] ctl,
                       input int ack_delay, output int cyc);
        issue(ins, src, rw, dst, mr, mw, m2r, ctl);
        wait_done(ack_delay, cyc);
    endtask

    // Reads a register through the ALU: ADD r + r0, no writeback
    task automatic read_reg(input logic [4:0] r, output logic [31:0] v);
        int cyc;
        run(rtype(r, 5'd0, 5'd0), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0010, 0, cyc);
        v = (cyc < 0) ? 32'hxxxx_xxxx : obs_result;
    endtask

    task automatic test_reset;
        int n_busy;
        rst = 1'b1; start = 1'b0; instruction = '0;
        ALUScr = 0; RegWrite = 0; RegDst = 0; MemRead = 0; MemWrite = 0; MemtoReg = 0;
        ALUControl = '0; mem_rdata = '0; mem_ack = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests++;
        if ({mem_req, mem_we, busy, done} !== 4'b0000) begin
            fails++; $display("FAIL reset_ctrl: got %b want 0000", {mem_req, mem_we, busy, done});
        end
        tests++;
        if (Zero !== 1'b1) begin fails++; $display("FAIL reset_zero: got %b want 1", Zero); end
        tests++;
        if ({mem_addr, mem_wdata, ALUResult, imm_ext} !== 128'd0) begin
            fails++; $display("FAIL reset_data: got %h %h %h %h want 0", mem_addr, mem_wdata, ALUResult, imm_ext);
        end
        rst = 1'b0;
        n_busy = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (busy !== 1'b0 || done !== 1'b0) n_busy++;
        end
        tests++;
        if (n_busy != 0) begin fails++; $display("FAIL idle_stays: got %0d busy/done cycles want 0", n_busy); end
    endtask

    task automatic test_write_read;
        int cyc;
        logic [31:0] v;
        run(itype(5'd0, 5'd1, 16'h7FFF), 1, 1, 0, 0, 0, 0, 4'b0010, 0, cyc);
        tests++;
        if (cyc != 3) begin fails++; $display("FAIL addi_done_cycle: got %0d want 3", cyc); end
        tests++;
        if (obs_result !== 32'h0000_7FFF) begin fails++; $display("FAIL addi_result: got %h want 00007fff", obs_result); end
        tests++;
        if (obs_zero !== 1'b0) begin fails++; $display("FAIL addi_zero: got %b want 0", obs_zero); end
        run(rtype(5'd1, 5'd1, 5'd2), 0, 1, 1, 0, 0, 0, 4'b0110, 0, cyc);
        tests++;
        if (cyc != 3) begin fails++; $display("FAIL sub_done_cycle: got %0d want 3", cyc); end
        tests++;
        if (obs_result !== 32'h0 || obs_zero !== 1'b1) begin
            fails++; $display("FAIL sub_result: got %h zero %b want 0 zero 1", obs_result, obs_zero);
        end
        read_reg(5'd1, v);
        tests++;
        if (v !== 32'h0000_7FFF) begin fails++; $display("FAIL read_r1: got %h want 00007fff", v); end
        read_reg(5'd2, v);
        tests++;
        if (v !== 32'h0) begin fails++; $display("FAIL read_r2: got %h want 0", v); end
    endtask

    task automatic test_alu_ops;
        logic [3:0]  ctl [8] = '{4'b0001, 4'b0000, 4'b0011, 4'b1100, 4'b1000, 4'b0110, 4'b1111, 4'b1000};
        logic [15:0] imm [8] = '{16'h8000, 16'h00F0, 16'h0F0F, 16'h0000, 16'h0004, 16'h0001, 16'h0001, 16'h0024};
        logic [31:0] exp [8] = '{32'hFFFF_FFFF, 32'h0000_00F0, 32'h0000_70F0, 32'hFFFF_8000,
                                 32'h0007_FFF0, 32'h0000_7FFE, 32'h0000_0000, 32'h0007_FFF0};
        int cyc;
        for (int i = 0; i < 8; i++) begin
            run(itype(5'd1, 5'd0, imm[i]), 1, 0, 0, 0, 0, 0, ctl[i], 0, cyc);
            tests++;
            if (obs_result !== exp[i]) begin
                fails++; $display("FAIL alu_op_%0d ctl %b: got %h want %h", i, ctl[i], obs_result, exp[i]);
            end
        end
    endtask

    task automatic test_sext_slt;
        int cyc;
        logic [31:0] v;
        run(itype(5'd0, 5'd3, 16'h8000), 1, 1, 0, 0, 0, 0, 4'b0010, 0, cyc);
        tests++;
        if (obs_imm !== 32'hFFFF_8000) begin fails++; $display("FAIL sext_imm: got %h want ffff8000", obs_imm); end
        tests++;
        if (obs_result !== 32'hFFFF_8000) begin fails++; $display("FAIL sext_result: got %h want ffff8000", obs_result); end
        run(itype(5'd0, 5'd4, 16'h0001), 1, 1, 0, 0, 0, 0, 4'b0010, 0, cyc);
        run(rtype(5'd3, 5'd4, 5'd5), 0, 1, 1, 0, 0, 0, 4'b0111, 0, cyc);
        tests++;
        if (obs_result !== 32'h1) begin fails++; $display("FAIL slt_neg_lt_1: got %h want 1", obs_result); end
        run(rtype(5'd4, 5'd3, 5'd6), 0, 0, 1, 0, 0, 0, 4'b0111, 0, cyc);
        tests++;
        if (obs_result !== 32'h0) begin fails++; $display("FAIL slt_1_lt_neg: got %h want 0", obs_result); end
        read_reg(5'd5, v);
        tests++;
        if (v !== 32'h1) begin fails++; $display("FAIL read_r5: got %h want 1", v); end
    endtask

    task automatic test_store_load;
        int cyc;
        logic [31:0] v;
        run(itype(5'd0, 5'd6, 16'h0100), 1, 1, 0, 0, 0, 0, 4'b0010, 0, cyc);
        run(itype(5'd6, 5'd1, 16'h0010), 1, 0, 0, 0, 1, 0, 4'b0010, 2, cyc);
        tests++;
        if (cyc != 6) begin fails++; $display("FAIL store_done_cycle: got %0d want 6", cyc); end
        tests++;
        if (obs_req_cycles != 3) begin fails++; $display("FAIL store_req_cycles: got %0d want 3", obs_req_cycles); end
        tests++;
        if (obs_addr !== 32'h110 || obs_we !== 1'b1 || obs_wdata !== 32'h7FFF) begin
            fails++; $display("FAIL store_bus: got addr %h we %b wdata %h want 110 1 7fff", obs_addr, obs_we, obs_wdata);
        end
        tests++;
        if (obs_stable !== 1'b1) begin fails++; $display("FAIL store_stable: got %b want 1", obs_stable); end
        mem_rdata = 32'hDEAD_BEEF;
        run(itype(5'd6, 5'd7, 16'h0010), 1, 1, 0, 1, 0, 1, 4'b0010, 2, cyc);
        tests++;
        if (cyc != 6) begin fails++; $display("FAIL load_done_cycle: got %0d want 6", cyc); end
        tests++;
        if (obs_we !== 1'b0 || obs_addr !== 32'h110) begin
            fails++; $display("FAIL load_bus: got we %b addr %h want 0 110", obs_we, obs_addr);
        end
        read_reg(5'd7, v);
        tests++;
        if (v !== 32'hDEAD_BEEF) begin fails++; $display("FAIL read_r7: got %h want deadbeef", v); end
        mem_rdata = 32'h5555_5555;
        run(itype(5'd6, 5'd8, 16'h0010), 1, 1, 0, 1, 1, 1, 4'b0010, 0, cyc);
        tests++;
        if (cyc != 4 || obs_we !== 1'b1) begin
            fails++; $display("FAIL rw_both: got cycle %0d we %b want 4 1", cyc, obs_we);
        end
        read_reg(5'd8, v);
        tests++;
        if (v !== 32'hDEAD_BEEF) begin fails++; $display("FAIL rw_both_mdr: got %h want deadbeef", v); end
    endtask

    task automatic test_r0_busy;
        int cyc;
        int n_done;
        logic [31:0] v, res;
        run(itype(5'd0, 5'd0, 16'h1234), 1, 1, 0, 0, 0, 0, 4'b0010, 0, cyc);
        tests++;
        if (obs_result !== 32'h1234) begin fails++; $display("FAIL r0_write_result: got %h want 1234", obs_result); end
        read_reg(5'd0, v);
        tests++;
        if (v !== 32'h0) begin fails++; $display("FAIL read_r0: got %h want 0", v); end
        issue(itype(5'd0, 5'd9, 16'h0042), 1, 1, 0, 0, 0, 0, 4'b0010);
        n_done = 0;
        res = 'x;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (done === 1'b1) begin n_done++; res = ALUResult; end
            if (c <= 3) begin
                start = 1'b1; instruction = itype(5'd0, 5'd10, 16'h0999); ALUControl = 4'b1100;
            end else begin
                start = 1'b0;
            end
        end
        tests++;
        if (n_done != 1) begin fails++; $display("FAIL busy_done_count: got %0d want 1", n_done); end
        tests++;
        if (res !== 32'h42) begin fails++; $display("FAIL busy_result: got %h want 42", res); end
        read_reg(5'd10, v);
        tests++;
        if (v !== 32'h0) begin fails++; $display("FAIL read_r10: got %h want 0", v); end
        read_reg(5'd9, v);
        tests++;
        if (v !== 32'h42) begin fails++; $display("FAIL read_r9: got %h want 42", v); end
    endtask

    task automatic test_reset_mem;
        int cyc;
        int seen;
        int n_busy;
        mem_rdata = 32'hCAFE_F00D;
        mem_ack = 1'b0;
        issue(itype(5'd0, 5'd11, 16'h0020), 1, 1, 0, 1, 0, 1, 4'b0010);
        seen = -1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (mem_req === 1'b1) begin seen = c; break; end
        end
        tests++;
        if (seen != 3) begin fails++; $display("FAIL mem_req_cycle: got %0d want 3", seen); end
        rst = 1'b1;
        @(negedge clk);
        tests++;
        if ({mem_req, busy, done} !== 3'b000) begin
            fails++; $display("FAIL reset_in_mem: got req/busy/done %b want 000", {mem_req, busy, done});
        end
        tests++;
        if (ALUResult !== 32'h0 || Zero !== 1'b1) begin
            fails++; $display("FAIL reset_in_mem_regs: got %h zero %b want 0 zero 1", ALUResult, Zero);
        end
        rst = 1'b0;
        mem_ack = 1'b1;
        n_busy = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (busy !== 1'b0 || done !== 1'b0) n_busy++;
        end
        mem_ack = 1'b0;
        tests++;
        if (n_busy != 0) begin fails++; $display("FAIL ack_in_idle: got %0d busy cycles want 0", n_busy); end
        run(itype(5'd11, 5'd0, 16'h0001), 1, 0, 0, 0, 0, 0, 4'b0010, 0, cyc);
        tests++;
        if (obs_result !== 32'h1 || cyc != 3) begin
            fails++; $display("FAIL r11_after_reset: got %h cycle %0d want 1 cycle 3", obs_result, cyc);
        end
    endtask

    initial begin
        test_reset;
        test_write_read;
        test_alu_ops;
        test_sext_slt;
        test_store_load;
        test_r0_busy;
        test_reset_mem;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
